data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving the pipelined CPU's MEM-stage load/store requests. It accepts a read or write request, holds the pipeline via `stall` for a fixed access latency, commits the access to an internal word-addressed RAM, and returns a one-cycle response. Illegal requests are flagged but still answered, so the pipeline never hangs.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Bus between the CPU MEM stage (master) and the data-memory responder (slave).
// Carries the request lines from the CPU and the stall/response lines back.
interface data_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        resp_valid;
    logic        error;
    logic [15:0] access_count;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, stall, resp_valid, error, access_count
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, stall, resp_valid, error, access_count
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Accepts one load/store, stalls the pipeline for LATENCY busy cycles,
// commits the access to a word-addressed RAM and pulses resp_valid for one
// cycle. Illegal requests run the full latency, are not executed, return 0
// and set a sticky error flag.
module data_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic                   r_rd;
    logic                   r_wr;
    logic [31:0]            r_read_data;
    logic                   r_resp_valid;
    logic                   r_error;
    logic [15:0]            r_access_count;
    logic [31:0]            r_mem [0:DEPTH-1];

    logic                   w_request;
    logic                   w_commit;
    logic                   w_misaligned;
    logic                   w_out_of_range;
    logic                   w_illegal;
    logic [ADDR_BITS-1:0]   w_index;

    assign w_request = bus.mem_read | bus.mem_write;

    // Legality is judged on the captured request, so lines that wander during
    // the stall cannot change the outcome.
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_index      = r_addr[ADDR_BITS+1:2];

    generate
        if (ADDR_BITS + 2 < 32) begin : g_range_check
            assign w_out_of_range = |r_addr[31:ADDR_BITS+2];
        end else begin : g_no_range_check
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_illegal = w_misaligned | w_out_of_range | (r_rd & r_wr);

    // Last BUSY cycle; reset suppresses the commit entirely.
    assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0) && !reset;

    // Hold the pipeline while a fresh request waits in IDLE and for all of BUSY.
    assign bus.stall = ((r_state == S_IDLE) && w_request) || (r_state == S_BUSY);

    assign bus.read_data    = r_read_data;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.error        = r_error;
    assign bus.access_count = r_access_count;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && r_wr && !w_illegal) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    // Control FSM: capture in IDLE, count down in BUSY, respond in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_rd           <= 1'b0;
            r_wr           <= 1'b0;
            r_read_data    <= 32'd0;
            r_resp_valid   <= 1'b0;
            r_error        <= 1'b0;
            r_access_count <= 16'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.write_data;
                        r_rd    <= bus.mem_read;
                        r_wr    <= bus.mem_write;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state        <= S_DONE;
                        r_resp_valid   <= 1'b1;
                        r_access_count <= r_access_count + 16'd1;
                        if (w_illegal) begin
                            r_error     <= 1'b1;
                            r_read_data <= 32'd0;
                        end else if (r_rd) begin
                            r_read_data <= r_mem[w_index];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // The CPU advances at the end of DONE; a still-held request
                    // is only seen again once we are back in IDLE.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=2 and LATENCY=1).
// A driver issues requests and pushes expected responses into a per-instance
// queue; a monitor pops and compares on every resp_valid pulse.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  drv_rd;
    logic [1:0]  drv_wr;
    logic [31:0] drv_addr [2];
    logic [31:0] drv_data [2];

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    assign bus_a.mem_read   = drv_rd[0];
    assign bus_a.mem_write  = drv_wr[0];
    assign bus_a.addr       = drv_addr[0];
    assign bus_a.write_data = drv_data[0];
    assign bus_b.mem_read   = drv_rd[1];
    assign bus_b.mem_write  = drv_wr[1];
    assign bus_b.addr       = drv_addr[1];
    assign bus_b.write_data = drv_data[1];

    data_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (rst[0]),
        .bus   (bus_a)
    );

    data_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_b (
        .clk   (clk),
        .reset (rst[1]),
        .bus   (bus_b)
    );

    logic [1:0] obs_stall;
    logic [1:0] obs_resp;
    assign obs_stall = {bus_b.stall, bus_a.stall};
    assign obs_resp  = {bus_b.resp_valid, bus_a.resp_valid};

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic [15:0] cnt;
        bit          chk_rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: memory contents and architectural outputs per instance.
    logic [31:0] model_mem [2][256];
    logic        model_err [2];
    logic [15:0] model_cnt [2];
    logic [31:0] model_rd  [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        model_err[k] = 1'b0;
        model_cnt[k] = 16'd0;
        model_rd[k]  = 32'd0;
    endtask

    // Issue one request on instance k starting in an IDLE cycle (cycle 0),
    // check stall length and response cycle. With hold=1 the lines stay up
    // after DONE so the next call continues the same held request.
    task automatic issue(input int k, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        exp_t e;
        int   lat;
        int   stalls;
        int   resp_cyc;
        bit   got;
        bit   illegal;
        lat      = (k == 0) ? 2 : 1;
        stalls   = 0;
        resp_cyc = -1;
        got      = 1'b0;
        drv_rd[k]   = rd;
        drv_wr[k]   = wr;
        drv_addr[k] = a;
        drv_data[k] = d;

        illegal = (a % 4 != 0) || (a >= 32'd1024) || (rd && wr);
        model_cnt[k] = model_cnt[k] + 16'd1;
        if (illegal) begin
            model_err[k] = 1'b1;
            model_rd[k]  = 32'd0;
        end else if (rd) begin
            model_rd[k] = model_mem[k][a / 4];
        end else begin
            model_mem[k][a / 4] = d;
        end
        e.rd     = model_rd[k];
        e.err    = model_err[k];
        e.cnt    = model_cnt[k];
        e.chk_rd = rd;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);

        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (obs_resp[k]) begin
                got      = 1'b1;
                resp_cyc = c;
                chk("stall_low_in_done", 32'(obs_stall[k]), 32'd0);
            end else begin
                if (obs_stall[k]) stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: dut %0d got no resp_valid, required one within 40 cycles", k);
        end else begin
            chk("stall_cycles", 32'(stalls), 32'(lat + 1));
            chk("resp_cycle", 32'(resp_cyc), 32'(lat + 1));
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            drv_rd[k] = 1'b0;
            drv_wr[k] = 1'b0;
        end
    endtask

    exp_t e0;
    exp_t e1;

    // Monitor: every resp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (obs_resp[0]) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: dut 0 pulsed resp_valid with no request outstanding");
            end else begin
                e0 = q0.pop_front();
                if (e0.chk_rd) chk("a_read_data", bus_a.read_data, e0.rd);
                chk("a_error", 32'(bus_a.error), 32'(e0.err));
                chk("a_access_count", 32'(bus_a.access_count), 32'(e0.cnt));
            end
        end
        if (obs_resp[1]) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: dut 1 pulsed resp_valid with no request outstanding");
            end else begin
                e1 = q1.pop_front();
                if (e1.chk_rd) chk("b_read_data", bus_b.read_data, e1.rd);
                chk("b_error", 32'(bus_b.error), 32'(e1.err));
                chk("b_access_count", 32'(bus_b.access_count), 32'(e1.cnt));
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] r_a;
    bit          r_rd;
    bit          r_wr;
    int          kind;

    initial begin
        rst      = 2'b11;
        drv_rd   = 2'b00;
        drv_wr   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            drv_addr[k] = 32'd0;
            drv_data[k] = 32'd0;
            model_reset(k);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;
        @(negedge clk);
        chk("reset_stall",      32'(bus_a.stall), 32'd0);
        chk("reset_resp",       32'(bus_a.resp_valid), 32'd0);
        chk("reset_error",      32'(bus_a.error), 32'd0);
        chk("reset_count",      32'(bus_a.access_count), 32'd0);
        chk("reset_read_data",  bus_a.read_data, 32'd0);
        chk("reset_b_stall",    32'(bus_b.stall), 32'd0);
        chk("reset_b_count",    32'(bus_b.access_count), 32'd0);
        @(posedge clk);
        #1;

        // Write then read back.
        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Preload the words used by the rest of the run.
        for (int w = 0; w < 16; w++) issue(0, 1'b0, 1'b1, 32'(w * 4), $urandom(), 1'b0);
        issue(0, 1'b0, 1'b1, 32'h20, 32'h55, 1'b0);

        // Misaligned read, out-of-range write, read+write together.
        issue(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(0, 1'b0, 1'b1, 32'h400, 32'h1, 1'b0);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        issue(0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Held read through DONE and one more cycle: exactly two acceptances.
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Randomized mix of legal and illegal accesses.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            r_a  = 32'($urandom_range(0, 15)) * 32'd4;
            r_rd = 1'($urandom_range(0, 1));
            r_wr = !r_rd;
            if (kind == 7) r_a = r_a + 32'($urandom_range(1, 3));
            if (kind == 8) r_a = r_a + 32'h400 * 32'($urandom_range(1, 100));
            if (kind == 9) begin
                r_rd = 1'b1;
                r_wr = 1'b1;
            end
            issue(0, r_rd, r_wr, r_a, $urandom(), 1'b0);
        end

        // Reset during the last BUSY cycle aborts the write.
        issue(0, 1'b0, 1'b1, 32'h20, 32'h55, 1'b0);
        drv_rd[0]   = 1'b0;
        drv_wr[0]   = 1'b1;
        drv_addr[0] = 32'h20;
        drv_data[0] = 32'h12345678;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0]    = 1'b0;
        drv_wr[0] = 1'b0;
        model_reset(0);
        @(negedge clk);
        chk("abort_stall", 32'(bus_a.stall), 32'd0);
        chk("abort_resp",  32'(bus_a.resp_valid), 32'd0);
        chk("abort_count", 32'(bus_a.access_count), 32'd0);
        chk("abort_error", 32'(bus_a.error), 32'd0);
        @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // LATENCY=1 instance.
        issue(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
